pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 125 ++++++++++++
 tb/tb_pc_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// Program-counter controller: IDLE/FETCH/EXEC/TRAP sequencer with retire counter.
// Optional overflow trap enabled by defining PC_CTRL_OVF_TRAP_EN.
module pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] target,
  input  logic        overflow,
  input  logic        stall,
  input  logic        imem_ready,
  input  logic        trap_clear,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic        inst_valid,
  output logic        trap,
  output logic [31:0] epc,
  output logic [31:0] instret
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_TRAP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] instret_nxt;
  logic        trap_cond;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

`ifdef PC_CTRL_OVF_TRAP_EN
  assign trap_cond = overflow;
`else
  assign trap_cond = 1'b0;
`endif

  assign pc_plus4   = pc + 32'd4;
  assign imem_req   = (state == S_FETCH);
  assign inst_valid = (state == S_EXEC);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    instret_nxt = instret;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ready) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        // stall outranks trap, branch and sequential advance
        if (!stall) begin
          if (trap_cond) begin
            pc_nxt    = TRAP_VEC;
            state_nxt = S_TRAP;
          end else if (branch_taken) begin
            pc_nxt      = word_align(target);
            instret_nxt = instret + 32'd1;
            state_nxt   = S_FETCH;
          end else begin
            pc_nxt      = pc_plus4;
            instret_nxt = instret + 32'd1;
            state_nxt   = S_FETCH;
          end
        end
      end
      S_TRAP: begin
`ifdef PC_CTRL_OVF_TRAP_EN
        if (trap_clear) state_nxt = S_FETCH;
`else
        state_nxt = S_FETCH;
`endif
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      instret <= 32'd0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      instret <= instret_nxt;
    end
  end

`ifdef PC_CTRL_OVF_TRAP_EN
  logic        trap_q;
  logic [31:0] epc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_q <= 1'b0;
      epc_q  <= 32'd0;
    end else if ((state == S_EXEC) && !stall && overflow) begin
      trap_q <= 1'b1;
      epc_q  <= pc;
    end else if ((state == S_TRAP) && trap_clear) begin
      trap_q <= 1'b0;
    end
  end

  assign trap = trap_q;
  assign epc  = epc_q;
`else
  logic unused_trap_inputs;
  assign unused_trap_inputs = overflow ^ trap_clear;
  assign trap = 1'b0;
  assign epc  = 32'd0;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Table-driven bench for pc_ctrl plus hand sequences for async reset and trap.
module tb_pc_ctrl;

  logic        clk;
  logic        rst;
  logic        branch_taken;
  logic [31:0] target;
  logic        overflow;
  logic        stall;
  logic        imem_ready;
  logic        trap_clear;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic        inst_valid;
  logic        trap;
  logic [31:0] epc;
  logic [31:0] instret;

  pc_ctrl dut (
    .clk(clk), .rst(rst), .branch_taken(branch_taken), .target(target),
    .overflow(overflow), .stall(stall), .imem_ready(imem_ready),
    .trap_clear(trap_clear), .pc(pc), .pc_plus4(pc_plus4),
    .imem_req(imem_req), .inst_valid(inst_valid), .trap(trap),
    .epc(epc), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        br;
    logic [31:0] tgt;
    logic        ovf;
    logic        clr;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_iv;
    logic [31:0] e_ret;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

`ifdef PC_CTRL_OVF_TRAP_EN
  localparam logic OVF_AT8 = 1'b0;
`else
  localparam logic OVF_AT8 = 1'b1;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic r, input logic b, input logic [31:0] t,
                     input logic o, input logic c, input logic [31:0] ep,
                     input logic er, input logic ei, input logic [31:0] et);
    vec_t v;
    v.stall = s; v.ready = r; v.br = b; v.tgt = t; v.ovf = o; v.clr = c;
    v.e_pc = ep; v.e_req = er; v.e_iv = ei; v.e_ret = et;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic s, input logic r, input logic b, input logic [31:0] t,
                       input logic o, input logic c);
    stall = s; imem_ready = r; branch_taken = b; target = t; overflow = o; trap_clear = c;
  endtask

  // one clock: drive, then land 1 time unit after the rising edge
  task automatic cyc(input logic s, input logic r, input logic b, input logic [31:0] t,
                     input logic o, input logic c);
    drive(s, r, b, t, o, c);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 32'h0, 0, 0);

    //   st rdy br target        ovf clr  exp_pc         req iv instret
    add(0, 0, 0, 32'h0,        0, 0,   32'h0000_0000, 0, 0, 32'd0);  // IDLE
    add(0, 1, 0, 32'h0,        0, 0,   32'h0000_0000, 1, 0, 32'd0);
    add(0, 0, 0, 32'h0,        0, 0,   32'h0000_0000, 0, 1, 32'd0);
    add(0, 1, 0, 32'h0,        0, 0,   32'h0000_0004, 1, 0, 32'd1);
    add(0, 0, 0, 32'h0,        0, 0,   32'h0000_0004, 0, 1, 32'd1);
    add(0, 1, 0, 32'h0,        0, 0,   32'h0000_0008, 1, 0, 32'd2);
    add(0, 0, 0, 32'h0,  OVF_AT8, 0,   32'h0000_0008, 0, 1, 32'd2);
    add(0, 1, 0, 32'h0,        1, 1,   32'h0000_000C, 1, 0, 32'd3);
    add(0, 0, 0, 32'h0,        0, 0,   32'h0000_000C, 0, 1, 32'd3);
    add(0, 1, 0, 32'h0,        0, 0,   32'h0000_0010, 1, 0, 32'd4);
    add(0, 0, 1, 32'h0000_0203, 0, 0,  32'h0000_0010, 0, 1, 32'd4);
    add(1, 0, 1, 32'h0000_0500, 0, 0,  32'h0000_0200, 1, 0, 32'd5);
    add(0, 1, 0, 32'h0,        0, 0,   32'h0000_0200, 1, 0, 32'd5);
    add(1, 0, 1, 32'h0000_0700, 1, 0,  32'h0000_0200, 0, 1, 32'd5);
    add(1, 0, 0, 32'h0,        0, 0,   32'h0000_0200, 0, 1, 32'd5);
    add(1, 1, 0, 32'h0,        0, 0,   32'h0000_0200, 0, 1, 32'd5);
    add(0, 1, 0, 32'h0,        0, 0,   32'h0000_0200, 0, 1, 32'd5);
    add(0, 0, 0, 32'h0,        0, 0,   32'h0000_0204, 1, 0, 32'd6);
    add(0, 0, 0, 32'h0,        0, 1,   32'h0000_0204, 1, 0, 32'd6);
    add(0, 1, 0, 32'h0,        0, 0,   32'h0000_0204, 1, 0, 32'd6);
    add(0, 0, 1, 32'hFFFF_FFFF, 0, 0,  32'h0000_0204, 0, 1, 32'd6);
    add(0, 1, 0, 32'h0,        0, 0,   32'hFFFF_FFFC, 1, 0, 32'd7);
    add(0, 0, 0, 32'h0,        0, 0,   32'hFFFF_FFFC, 0, 1, 32'd7);
    add(0, 1, 0, 32'h0,        0, 0,   32'h0000_0000, 1, 0, 32'd8);
    add(0, 0, 0, 32'h0,        0, 0,   32'h0000_0000, 0, 1, 32'd8);
    add(0, 0, 0, 32'h0,        0, 0,   32'h0000_0004, 1, 0, 32'd9);

    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_iv", {31'd0, inst_valid}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_epc", epc, 32'h0);
    chk("rst_instret", instret, 32'd0);

    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].stall, tbl[i].ready, tbl[i].br, tbl[i].tgt, tbl[i].ovf, tbl[i].clr);
      @(negedge clk);
      chk($sformatf("v%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("v%0d_pc_plus4", i), pc_plus4, tbl[i].e_pc + 32'd4);
      chk($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("v%0d_iv", i), {31'd0, inst_valid}, {31'd0, tbl[i].e_iv});
      chk($sformatf("v%0d_instret", i), instret, tbl[i].e_ret);
      chk($sformatf("v%0d_trap", i), {31'd0, trap}, 32'd0);
      chk($sformatf("v%0d_epc", i), epc, 32'h0);
      @(posedge clk);
      #1;
    end

    // still in FETCH at pc 4 with instret 9: async reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_iv", {31'd0, inst_valid}, 32'd0);
    chk("async_trap", {31'd0, trap}, 32'd0);
    chk("async_epc", epc, 32'h0);
    chk("async_instret", instret, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd0);

`ifdef PC_CTRL_OVF_TRAP_EN
    cyc(0, 0, 0, 32'h0, 0, 0);                // IDLE
    cyc(0, 1, 0, 32'h0, 0, 0);                // FETCH
    cyc(0, 0, 1, 32'h0000_0024, 0, 0);        // EXEC branch to 0x24
    chk("tr_fetch_pc", pc, 32'h24);
    cyc(0, 1, 0, 32'h0, 0, 0);
    chk("tr_exec_iv", {31'd0, inst_valid}, 32'd1);
    cyc(1, 0, 1, 32'h0000_0300, 1, 0);        // stalled overflow does nothing
    chk("tr_stall_trap", {31'd0, trap}, 32'd0);
    chk("tr_stall_pc", pc, 32'h24);
    cyc(0, 0, 1, 32'h0000_0300, 1, 0);        // overflow beats branch
    chk("tr_trap", {31'd0, trap}, 32'd1);
    chk("tr_epc", epc, 32'h24);
    chk("tr_pc", pc, 32'h80);
    chk("tr_instret", instret, 32'd1);
    chk("tr_req", {31'd0, imem_req}, 32'd0);
    chk("tr_iv", {31'd0, inst_valid}, 32'd0);
    cyc(0, 1, 0, 32'h0, 0, 0);
    chk("tr_hold_trap", {31'd0, trap}, 32'd1);
    chk("tr_hold_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 0, 32'h0, 0, 1);
    chk("tr_clr_trap", {31'd0, trap}, 32'd0);
    chk("tr_clr_req", {31'd0, imem_req}, 32'd1);
    chk("tr_clr_pc", pc, 32'h80);
    chk("tr_clr_epc", epc, 32'h24);
    cyc(0, 1, 0, 32'h0, 0, 0);
    chk("tr_resume_iv", {31'd0, inst_valid}, 32'd1);
    chk("tr_resume_pc", pc, 32'h80);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
